// File: rtl/ant_switch_multi.sv
// ant_switch_multi: N-antenna receive-diversity selector with RSSI hysteresis and a fixed collection window
module ant_switch_multi #(
  parameter int NUM_ANT       = 4,
  parameter int SEL_WIDTH     = 2,
  parameter int RSSI_WIDTH    = 11,
  parameter int PHASE_WIDTH   = 32,
  parameter int TIMEOUT_WIDTH = 4,
  parameter int HYST_HALF_DB  = 6
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [NUM_ANT-1:0]             preamble_det_bus,
  input  logic [NUM_ANT-1:0]             power_trigger_bus,
  input  logic [NUM_ANT*RSSI_WIDTH-1:0]  rssi_bus,
  input  logic [NUM_ANT*PHASE_WIDTH-1:0] phase_offset_bus,
  input  logic                           force_en,
  input  logic [SEL_WIDTH-1:0]           force_ant,
  output logic                           short_preamble_detected,
  output logic [SEL_WIDTH-1:0]           ant_select,
  output logic [PHASE_WIDTH-1:0]         phase_offset,
  output logic                           locked,
  output logic [3:0]                     switch_count
);
  localparam int NSEL = 2**SEL_WIDTH;
  typedef enum logic [1:0] {IDLE, COLLECT, LOCK} state_t;
  state_t                   state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0]     cand_q, cand_d, ant_select_q, ant_select_d;
  logic [PHASE_WIDTH-1:0]   cand_phase_q, cand_phase_d, phase_offset_q, phase_offset_d;
  logic [RSSI_WIDTH-1:0]    cand_rssi_q, cand_rssi_d;
  logic [3:0]               switch_count_q, switch_count_d;
  logic                     pulse_q, pulse_d, locked_q, locked_d;
  logic [NSEL-1:0]          pt_ext;
  logic [RSSI_WIDTH:0]      thresh;
  logic [NUM_ANT-1:0]       elig, chal;
  logic                     elig_any, chal_any;
  logic [SEL_WIDTH-1:0]     elig_idx, chal_idx;
  logic [RSSI_WIDTH-1:0]    elig_rssi, chal_rssi;
  logic [PHASE_WIDTH-1:0]   elig_phase, chal_phase;
  assign pt_ext = NSEL'(power_trigger_bus);
  assign thresh = {1'b0, cand_rssi_q} + (RSSI_WIDTH+1)'(HYST_HALF_DB);
  // Eligibility masks and strongest antenna of each set; ties resolve to the lowest index
  always_comb begin
    elig       = '0;
    chal       = '0;
    elig_any   = 1'b0;
    elig_idx   = '0;
    elig_rssi  = '0;
    elig_phase = '0;
    chal_any   = 1'b0;
    chal_idx   = '0;
    chal_rssi  = '0;
    chal_phase = '0;
    for (int i = 0; i < NUM_ANT; i++) begin
      elig[i] = preamble_det_bus[i] && (!force_en || force_ant == SEL_WIDTH'(i));
      chal[i] = elig[i] && cand_q != SEL_WIDTH'(i) &&
                {1'b0, rssi_bus[i*RSSI_WIDTH +: RSSI_WIDTH]} > thresh;
      if (elig[i] && (!elig_any || rssi_bus[i*RSSI_WIDTH +: RSSI_WIDTH] > elig_rssi)) begin
        elig_any   = 1'b1;
        elig_idx   = SEL_WIDTH'(i);
        elig_rssi  = rssi_bus[i*RSSI_WIDTH +: RSSI_WIDTH];
        elig_phase = phase_offset_bus[i*PHASE_WIDTH +: PHASE_WIDTH];
      end
      if (chal[i] && (!chal_any || rssi_bus[i*RSSI_WIDTH +: RSSI_WIDTH] > chal_rssi)) begin
        chal_any   = 1'b1;
        chal_idx   = SEL_WIDTH'(i);
        chal_rssi  = rssi_bus[i*RSSI_WIDTH +: RSSI_WIDTH];
        chal_phase = phase_offset_bus[i*PHASE_WIDTH +: PHASE_WIDTH];
      end
    end
  end
  // Next state: open a window on detect, replace the candidate on a clear win, lock at window end
  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    cand_d         = cand_q;
    cand_phase_d   = cand_phase_q;
    cand_rssi_d    = cand_rssi_q;
    ant_select_d   = ant_select_q;
    phase_offset_d = phase_offset_q;
    switch_count_d = switch_count_q;
    if (!enable) state_d = IDLE;
    else case (state_q)
      IDLE: if (elig_any) begin
        state_d        = COLLECT;
        cand_d         = elig_idx;
        cand_phase_d   = elig_phase;
        cand_rssi_d    = elig_rssi;
        switch_count_d = '0;
      end
      COLLECT: if (!pt_ext[cand_q]) state_d = IDLE;
      else begin
        if (chal_any) begin
          cand_d         = chal_idx;
          cand_phase_d   = chal_phase;
          cand_rssi_d    = chal_rssi;
          switch_count_d = switch_count_q + {3'b0, switch_count_q != 4'hf};
        end
        if (cnt_q == '1) begin
          state_d        = LOCK;
          ant_select_d   = cand_d;
          phase_offset_d = cand_phase_d;
        end else cnt_d = cnt_q + 1'b1;
      end
      LOCK: if (!pt_ext[ant_select_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pulse_d  = state_q == COLLECT && state_d == LOCK;
    locked_d = state_d == LOCK;
  end
  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cand_q         <= '0;
      cand_phase_q   <= '0;
      cand_rssi_q    <= '0;
      ant_select_q   <= '0;
      phase_offset_q <= '0;
      switch_count_q <= '0;
      pulse_q        <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cand_q         <= cand_d;
      cand_phase_q   <= cand_phase_d;
      cand_rssi_q    <= cand_rssi_d;
      ant_select_q   <= ant_select_d;
      phase_offset_q <= phase_offset_d;
      switch_count_q <= switch_count_d;
      pulse_q        <= pulse_d;
      locked_q       <= locked_d;
    end
  end
  assign short_preamble_detected = pulse_q;
  assign ant_select              = ant_select_q;
  assign phase_offset            = phase_offset_q;
  assign locked                  = locked_q;
  assign switch_count            = switch_count_q;
endmodule

// File: tb/tb_ant_switch_multi.sv
// tb_ant_switch_multi: vector table, directed corner sequences and random stimulus against a reference model
module tb_ant_switch_multi;
  localparam int WIN  = 16;
  localparam int HYST = 6;
  logic        clock = 1'b0;
  logic        reset_n, enable, force_en;
  logic [1:0]  force_ant;
  logic [3:0]  det, pt;
  logic [10:0] rssi [4];
  logic [31:0] ph [4];
  logic [3:0]  preamble_det_bus, power_trigger_bus;
  logic [43:0] rssi_bus;
  logic [127:0] phase_offset_bus;
  logic        short_preamble_detected, locked;
  logic [1:0]  ant_select;
  logic [31:0] phase_offset;
  logic [3:0]  switch_count;
  int vectors = 0, miscompares = 0;
  int m_mode, m_cand, m_crssi, m_age, m_sel, m_sw;
  logic [31:0] m_cphase, m_phase;
  bit m_pulse, m_locked;
  typedef struct {
    logic [3:0] det;
    int         r [4];
    bit         fen;
    int         fant;
    int         exp_sel;
    bit         exp_lock;
  } vec_t;
  vec_t tab [8];

  always #5 clock = ~clock;
  assign preamble_det_bus  = det;
  assign power_trigger_bus = pt;
  assign rssi_bus          = {rssi[3], rssi[2], rssi[1], rssi[0]};
  assign phase_offset_bus  = {ph[3], ph[2], ph[1], ph[0]};

  ant_switch_multi dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .preamble_det_bus(preamble_det_bus), .power_trigger_bus(power_trigger_bus),
    .rssi_bus(rssi_bus), .phase_offset_bus(phase_offset_bus),
    .force_en(force_en), .force_ant(force_ant),
    .short_preamble_detected(short_preamble_detected), .ant_select(ant_select),
    .phase_offset(phase_offset), .locked(locked), .switch_count(switch_count)
  );

  function automatic void check(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic bit elig(int i);
    return det[i] && (!force_en || int'(force_ant) == i);
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_cand = 0; m_crssi = 0; m_age = 0; m_sel = 0; m_sw = 0;
    m_cphase = '0; m_phase = '0; m_pulse = 0; m_locked = 0;
  endfunction

  // Modes: 0 waiting for a detect, 1 collecting, 2 locked
  function automatic void model_step();
    int b, c;
    m_pulse = 0;
    if (!enable) m_mode = 0;
    else if (m_mode == 0) begin
      b = -1;
      for (int i = 0; i < 4; i++)
        if (elig(i) && (b < 0 || rssi[i] > rssi[b])) b = i;
      if (b >= 0) begin
        m_cand = b; m_cphase = ph[b]; m_crssi = int'(rssi[b]); m_sw = 0; m_age = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (!pt[m_cand]) m_mode = 0;
      else begin
        c = -1;
        for (int i = 0; i < 4; i++)
          if (elig(i) && i != m_cand && int'(rssi[i]) > m_crssi + HYST && (c < 0 || rssi[i] > rssi[c])) c = i;
        if (c >= 0) begin
          m_cand = c; m_cphase = ph[c]; m_crssi = int'(rssi[c]); m_sw = m_sw < 15 ? m_sw + 1 : 15;
        end
        m_age++;
        if (m_age == WIN) begin
          m_mode = 2; m_sel = m_cand; m_phase = m_cphase; m_pulse = 1;
        end
      end
    end else if (!pt[m_sel]) m_mode = 0;
    m_locked = m_mode == 2;
  endfunction

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check("pulse", 32'(short_preamble_detected), 32'(m_pulse));
    check("locked", 32'(locked), 32'(m_locked));
    check("ant_select", 32'(ant_select), 32'(m_sel));
    check("phase_offset", phase_offset, m_phase);
    check("switch_count", 32'(switch_count), 32'(m_sw));
  endtask

  task automatic check_zero(string n);
    check({n, "_pulse"}, 32'(short_preamble_detected), 0);
    check({n, "_locked"}, 32'(locked), 0);
    check({n, "_sel"}, 32'(ant_select), 0);
    check({n, "_phase"}, phase_offset, 0);
    check({n, "_swcnt"}, 32'(switch_count), 0);
  endtask

  task automatic do_reset();
    reset_n = 0; enable = 1; force_en = 0; force_ant = 0; det = 0; pt = 4'hf;
    #1;
    check_zero("reset");
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  task automatic wait_pulse(inout int k);
    while (!short_preamble_detected && k < 40) begin
      cycle();
      k++;
    end
  endtask

  task automatic set_vec(int n, logic [3:0] d, int r0, int r1, int r2, int r3, bit fen, int fant, int sel, bit lk);
    tab[n].det = d;
    tab[n].r[0] = r0; tab[n].r[1] = r1; tab[n].r[2] = r2; tab[n].r[3] = r3;
    tab[n].fen = fen; tab[n].fant = fant; tab[n].exp_sel = sel; tab[n].exp_lock = lk;
  endtask

  initial begin
    int k, pulses;
    set_vec(0, 4'b0100, 100, 100, 100, 100, 0, 0, 2, 1);
    set_vec(1, 4'b0110, 0, 200, 200, 0, 0, 0, 1, 1);
    set_vec(2, 4'b0110, 0, 200, 201, 0, 0, 0, 2, 1);
    set_vec(3, 4'b1111, 50, 50, 50, 60, 0, 0, 3, 1);
    set_vec(4, 4'b0010, 0, 500, 0, 0, 1, 3, 0, 0);
    set_vec(5, 4'b1010, 0, 500, 0, 50, 1, 3, 3, 1);
    set_vec(6, 4'b0001, 7, 900, 900, 900, 0, 0, 0, 1);
    set_vec(7, 4'b1000, 0, 0, 0, 2047, 0, 0, 3, 1);
    for (int i = 0; i < 4; i++) begin
      rssi[i] = 0;
      ph[i] = 32'hA000_0000 + 32'(i) * 32'h0111_1011;
    end
    do_reset();
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int i = 0; i < 4; i++) rssi[i] = 11'(tab[v].r[i]);
      force_en = tab[v].fen;
      force_ant = 2'(tab[v].fant);
      det = tab[v].det;
      cycle();
      det = 0;
      k = 1;
      if (tab[v].exp_lock) begin
        wait_pulse(k);
        check("tab_latency", 32'(k), 17);
        check("tab_sel", 32'(ant_select), 32'(tab[v].exp_sel));
        check("tab_phase", phase_offset, ph[tab[v].exp_sel]);
        check("tab_locked", 32'(locked), 1);
      end else begin
        repeat (20) cycle();
        check("tab_nolock", 32'(locked), 0);
      end
    end
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      rssi[0] = 100;
      rssi[3] = rep == 0 ? 11'd110 : 11'd106;
      det = 4'b0001; cycle(); det = 0;
      repeat (4) cycle();
      det = 4'b1000; cycle(); det = 0;
      k = 6;
      wait_pulse(k);
      check("hyst_latency", 32'(k), 17);
      check("hyst_sel", 32'(ant_select), rep == 0 ? 3 : 0);
      check("hyst_swcnt", 32'(switch_count), rep == 0 ? 1 : 0);
    end
    do_reset();
    det = 4'b0001; cycle(); det = 0;
    repeat (7) cycle();
    pt = 4'b1110;
    pulses = 0;
    repeat (30) begin
      cycle();
      pulses += int'(short_preamble_detected);
    end
    check("pwrdrop_pulses", 32'(pulses), 0);
    check("pwrdrop_locked", 32'(locked), 0);
    pt = 4'hf;
    det = 4'b0001; cycle(); det = 0;
    k = 1;
    wait_pulse(k);
    check("restart_latency", 32'(k), 17);
    do_reset();
    force_en = 1; force_ant = 3; rssi[1] = 500; rssi[3] = 50;
    det = 4'b0010; cycle(); det = 0;
    repeat (3) cycle();
    det = 4'b1000; cycle(); det = 0;
    k = 1;
    wait_pulse(k);
    check("force_latency", 32'(k), 17);
    check("force_sel", 32'(ant_select), 3);
    do_reset();
    for (int i = 0; i < 4; i++) rssi[i] = 300;
    det = 4'b0100; cycle(); det = 0;
    k = 1;
    wait_pulse(k);
    pt = 4'b1011; cycle(); pt = 4'hf;
    det = 4'b0001; cycle(); det = 0;
    repeat (4) cycle();
    check("collect_hold_sel", 32'(ant_select), 2);
    #2 reset_n = 0;
    #1 check_zero("async_collect");
    model_reset();
    @(posedge clock); #1 reset_n = 1;
    det = 4'b0100; cycle(); det = 0;
    k = 1;
    wait_pulse(k);
    cycle();
    check("lock_sel", 32'(ant_select), 2);
    check("lock_locked", 32'(locked), 1);
    #2 reset_n = 0;
    #1 check_zero("async_lock");
    model_reset();
    @(posedge clock); #1 reset_n = 1;
    det = 4'b0100; cycle(); det = 0;
    k = 1;
    wait_pulse(k);
    enable = 0;
    cycle();
    check("dis_locked", 32'(locked), 0);
    check("dis_sel", 32'(ant_select), 2);
    enable = 1;
    cycle();
    do_reset();
    repeat (3000) begin
      for (int i = 0; i < 4; i++) begin
        det[i] = $urandom_range(0, 5) == 0;
        pt[i] = $urandom_range(0, 63) != 0;
        rssi[i] = 11'(1000 + $urandom_range(0, 16));
        ph[i] = $urandom;
      end
      force_en = $urandom_range(0, 7) == 0;
      force_ant = 2'($urandom_range(0, 3));
      enable = $urandom_range(0, 99) != 0;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
